// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM scan multiplexer: output FSM
// encoding, mode codes and the channel-index width helper.
package tdm_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SCAN  = 1'b1;

  // Channel-index width; a single channel still needs one select bit.
  function automatic int sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/tdm_scan_mux_if.sv
// Channel-bus and output-beat signals of the TDM scan multiplexer.
// The master drives channels, controls and out_ready; the slave returns the beat.
interface tdm_scan_mux_if
  import tdm_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W    = 8
);
  localparam int SELW = sel_width(N_CH);

  logic [N_CH*W-1:0] data;
  logic [N_CH-1:0]   ch_en;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [W-1:0]      out_data;
  logic [SELW-1:0]   out_ch;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output data, ch_en, mode, sel, out_ready,
    input  out_data, out_ch, out_valid
  );

  modport slave (
    input  data, ch_en, mode, sel, out_ready,
    output out_data, out_ch, out_valid
  );

endinterface

// File: rtl/rr_next_sel.sv
// Combinational search for the first enabled channel at or above the scan
// pointer, wrapping modulo N_CH.
module rr_next_sel
  import tdm_pkg::*;
#(
  parameter int N_CH = 8,
  localparam int SELW = sel_width(N_CH)
) (
  input  logic [SELW-1:0] i_ptr,
  input  logic [N_CH-1:0] i_ch_en,
  output logic [SELW-1:0] o_sel,
  output logic            o_found
);

  localparam logic [SELW:0] N_CH_V = (SELW+1)'(N_CH);

  logic [SELW:0] w_idx;

  // NOTE: every output and temporary gets a default at the top of the block,
  // so no path through the loop can leave a value held (no latch).
  always_comb begin
    o_sel   = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_idx = {1'b0, i_ptr} + (SELW+1)'(i);
      if (w_idx >= N_CH_V) w_idx = w_idx - N_CH_V;
      if (!o_found && i_ch_en[w_idx[SELW-1:0]]) begin
        o_found = 1'b1;
        o_sel   = w_idx[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/tdm_scan_mux.sv
// TDM channel multiplexer: fixed-select or round-robin scan of enabled channels
// into a single registered output beat with valid/ready flow control.
module tdm_scan_mux
  import tdm_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  tdm_scan_mux_if.slave bus
);

  localparam int            SELW    = sel_width(N_CH);
  localparam logic [SELW:0] N_CH_V  = (SELW+1)'(N_CH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(N_CH - 1);

  state_t          r_state;
  logic [SELW-1:0] r_ptr;
  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_ch;

  logic [W-1:0]    w_ch_data [N_CH];
  logic [SELW-1:0] w_rr_sel;
  logic            w_rr_found;
  logic            w_scan;
  logic            w_sel_ok;
  logic            w_open;
  logic            w_load;
  logic [SELW-1:0] w_cand;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign w_ch_data[k] = bus.data[k*W +: W];
  end

  rr_next_sel #(.N_CH(N_CH)) u_rr_next_sel (
    .i_ptr   (r_ptr),
    .i_ch_en (bus.ch_en),
    .o_sel   (w_rr_sel),
    .o_found (w_rr_found)
  );

  assign w_scan   = (bus.mode == MODE_SCAN);
  assign w_sel_ok = ({1'b0, bus.sel} < N_CH_V) && bus.ch_en[bus.sel];
  assign w_open   = (r_state == EMPTY) || bus.out_ready;
  assign w_cand   = w_scan ? w_rr_sel : bus.sel;
  assign w_load   = w_scan ? w_rr_found : w_sel_ok;

  // A held beat is only replaced when the slot opens; a slot that opens with
  // nothing to load drops to EMPTY but keeps the last data/channel visible.
  // NOTE: all state here uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_ptr      <= '0;
      r_out_data <= '0;
      r_out_ch   <= '0;
    end else if (w_open) begin
      if (w_load) begin
        r_state    <= FULL;
        r_out_data <= w_ch_data[w_cand];
        r_out_ch   <= w_cand;
        if (w_scan) r_ptr <= (w_cand == LAST_CH) ? '0 : w_cand + SELW'(1);
      end else begin
        r_state <= EMPTY;
      end
    end
  end

  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;

endmodule

// File: tb/tb_tdm_scan_mux.sv
// Directed bench for tdm_scan_mux at N_CH=8, W=8 with channel k carrying 8'h10+k.
module tb_tdm_scan_mux;
  import tdm_pkg::*;

  localparam int N_CH = 8;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  tdm_scan_mux_if #(.N_CH(N_CH), .W(W)) bus ();

  tdm_scan_mux #(.N_CH(N_CH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic beat(input string tag, input logic v, input logic [7:0] d, input logic [2:0] c);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".data"},  32'(bus.out_data),  32'(d));
    check({tag, ".ch"},    32'(bus.out_ch),    32'(c));
  endtask

  logic [2:0] wrap_seq [5];
  logic [7:0] wrap_dat [5];

  initial begin
    for (int k = 0; k < N_CH; k++) bus.data[k*W +: W] = 8'(8'h10 + k);
    wrap_seq = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
    wrap_dat = '{8'h10, 8'h12, 8'h17, 8'h10, 8'h12};

    // Reset wins over a load that is ready to happen.
    bus.mode = MODE_FIXED; bus.sel = 3'd3; bus.ch_en = 8'hFF; bus.out_ready = 1'b1;
    @(negedge clk);
    do_reset();
    beat("reset", 1'b0, 8'h00, 3'd0);

    // First edge after reset loads the fixed channel.
    step();
    beat("fixed", 1'b1, 8'h13, 3'd3);
    // Fixed load left ptr at 0, so scan starts from channel 0.
    bus.mode = MODE_SCAN;
    step();
    beat("fixed_ptr", 1'b1, 8'h10, 3'd0);

    // Scan wrap over a sparse mask.
    bus.ch_en = 8'h00;
    do_reset();
    bus.ch_en = 8'b1000_0101;
    for (int i = 0; i < 5; i++) begin
      step();
      beat($sformatf("wrap%0d", i), 1'b1, wrap_dat[i], wrap_seq[i]);
    end

    // Backpressure holds the beat, including against a mask change.
    bus.ch_en = 8'h00;
    do_reset();
    bus.ch_en = 8'hFF; bus.out_ready = 1'b0;
    step();
    beat("bp_first", 1'b1, 8'h10, 3'd0);
    bus.ch_en = 8'h40;
    for (int i = 0; i < 4; i++) begin
      step();
      beat($sformatf("bp_hold%0d", i), 1'b1, 8'h10, 3'd0);
    end
    bus.ch_en = 8'hFF; bus.out_ready = 1'b1;
    step();
    beat("bp_release", 1'b1, 8'h11, 3'd1);

    // Empty mask never loads; a single enabled channel is found and re-found
    // after the pointer wraps past it.
    bus.ch_en = 8'h00;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("empty%0d.valid", i), 32'(bus.out_valid), 32'd0);
    end
    bus.ch_en = 8'h20;
    step();
    beat("mask5", 1'b1, 8'h15, 3'd5);
    step();
    beat("mask5_again", 1'b1, 8'h15, 3'd5);
    bus.ch_en = 8'h00;
    step();
    beat("drain_keep", 1'b0, 8'h15, 3'd5);

    // Fixed select on a disabled channel stays empty until enabled.
    do_reset();
    bus.mode = MODE_FIXED; bus.sel = 3'd3; bus.ch_en = 8'hF7;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("inval%0d.valid", i), 32'(bus.out_valid), 32'd0);
    end
    bus.ch_en = 8'hFF;
    step();
    beat("inval_en", 1'b1, 8'h13, 3'd3);

    // Reset mid-beat discards the held beat and clears the pointer.
    bus.ch_en = 8'h00;
    do_reset();
    bus.mode = MODE_SCAN; bus.ch_en = 8'hFF; bus.out_ready = 1'b1;
    step();
    beat("mid0", 1'b1, 8'h10, 3'd0);
    step();
    beat("mid1", 1'b1, 8'h11, 3'd1);
    bus.out_ready = 1'b0;
    step();
    beat("mid_hold", 1'b1, 8'h11, 3'd1);
    do_reset();
    beat("mid_rst", 1'b0, 8'h00, 3'd0);
    bus.out_ready = 1'b1;
    step();
    beat("mid_after", 1'b1, 8'h10, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tdm_scan_mux.md
TDM_SCAN_MUX -- requirements
Module: tdm_scan_mux

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of input channels (2..64).
REQ-002 SHALL have parameter W, default 8, bits per channel.
REQ-003 SHALL have derived constant SELW = max(1, clog2(N_CH)), the channel-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 data  input  N_CH*W  packed channels; channel k occupies bits [k*W+W-1 : k*W].
REQ-007 ch_en  input  N_CH  per-channel enable mask; bit k set = channel k eligible.
REQ-008 mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-009 sel  input  SELW  channel index used in fixed mode.
REQ-010 out_data  output  W  registered selected channel value.
REQ-011 out_ch  output  SELW  index of the channel held in out_data.
REQ-012 out_valid  output  1  out_data/out_ch hold a beat.
REQ-013 out_ready  input  1  downstream accepts the beat when out_valid && out_ready.

Function
REQ-014 SHALL implement a two-state output FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL load when the slot opens: state EMPTY, or state FULL with out_ready=1 in the same cycle.
REQ-016 Fixed mode load: candidate is sel; load only if sel < N_CH and ch_en[sel]=1; otherwise no load.
REQ-017 Scan mode load: candidate is the first index c with ch_en[c]=1, searched from ptr upward with wrap modulo N_CH; no load if ch_en is all zero.
REQ-018 On load: out_data <= data[c], out_ch <= c, state <= FULL; latency 1 cycle from input to out_data.
REQ-019 Slot open with no load: state <= EMPTY; out_data and out_ch keep their last values.
REQ-020 While FULL and out_ready=0: out_data and out_ch SHALL remain stable; inputs are ignored.
REQ-021 Scan pointer ptr (SELW bits, internal) SHALL update only on a scan-mode load: ptr <= (c+1) mod N_CH, including wrap N_CH-1 -> 0.
REQ-022 Fixed-mode loads SHALL NOT modify ptr.
REQ-023 mode, sel and ch_en changes SHALL take effect at the next load; a held beat is never replaced.
REQ-024 Back-to-back: FULL with out_ready=1 continuously SHALL yield one beat per cycle.

Reset
REQ-025 With rst=1 at a rising edge: state <= EMPTY, out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-026 Reset SHALL take priority over a simultaneous load or accept; a held beat is discarded.
REQ-027 The first load SHALL be possible on the first edge after rst deasserts.

Structure
REQ-028 Shared package tdm_pkg SHALL hold the FSM state encoding (EMPTY, FULL) and the mode constants (MODE_FIXED=0, MODE_SCAN=1).
REQ-029 Next-enabled-channel search (ptr, ch_en -> c, found) SHALL be a combinational sub-module rr_next_sel, parametrised by N_CH.
REQ-030 Top-level SHALL hold only the FSM, the ptr register, the output registers and the W-bit channel select.

Verification (N_CH=8, W=8; channel k data = 8'h10+k)
REQ-031 Fixed: mode=0, sel=3, ch_en=8'hFF, out_ready=1 -> next cycle out_valid=1, out_data=8'h13, out_ch=3; ptr stays 0.
REQ-032 Scan wrap: mode=1, ch_en=8'b1000_0101, out_ready=1 -> out_ch sequence 0,2,7,0,2 on consecutive cycles.
REQ-033 Backpressure: scan, ch_en=8'hFF, out_ready=0 for 4 cycles after first beat -> out_data=8'h10 held 4 cycles, then 8'h11 one cycle after out_ready=1.
REQ-034 Empty mask: mode=1, ch_en=0 -> out_valid=0 on every cycle; setting ch_en=8'h20 -> out_ch=5 next cycle.
REQ-035 Invalid select: mode=0, sel=3, ch_en=8'hF7 -> out_valid stays 0; enabling bit 3 -> out_data=8'h13.
REQ-036 Reset mid-beat: FULL with out_ready=0, assert rst one cycle -> out_valid=0, out_data=0, out_ch=0; next scan beat is from channel 0.
